// File: rtl/issue_queue_param.sv
// Parameterised out-of-order issue queue.
//
// Holds up to DEPTH decoded instructions. Each entry carries NSRC source
// operands that wake up when a matching result tag is broadcast. Every cycle
// the oldest ready entry (smallest age) is moved into a registered issue
// stage. A selective flush squashes everything younger than flush_age.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   enq_*               enqueue handshake, age, payload, per-source tag/busy/data
//   bc_valid/tag/data   NBC result broadcast ports (lowest port wins on a tie)
//   flush, flush_age    squash entries and issue stage with age > flush_age
//   iss_*               registered issue handshake, payload, operands, age
//   count               number of occupied queue entries (issue stage excluded)
module issue_queue_param #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned NBC   = 2,
  parameter int unsigned TAGW  = 6,
  parameter int unsigned DATAW = 32,
  parameter int unsigned PAYW  = 138,
  parameter int unsigned AGEW  = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [AGEW-1:0]            enq_age,
  input  logic [PAYW-1:0]            enq_payload,
  input  logic [NSRC*TAGW-1:0]       enq_tag,
  input  logic [NSRC-1:0]            enq_busy,
  input  logic [NSRC*DATAW-1:0]      enq_data,
  input  logic [NBC-1:0]             bc_valid,
  input  logic [NBC*TAGW-1:0]        bc_tag,
  input  logic [NBC*DATAW-1:0]       bc_data,
  input  logic                       flush,
  input  logic [AGEW-1:0]            flush_age,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [PAYW-1:0]            iss_payload,
  output logic [NSRC*DATAW-1:0]      iss_data,
  output logic [AGEW-1:0]            iss_age,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [AGEW-1:0]        age_q  [DEPTH];
  logic [AGEW-1:0]        age_d  [DEPTH];
  logic [PAYW-1:0]        pay_q  [DEPTH];
  logic [PAYW-1:0]        pay_d  [DEPTH];
  logic [NSRC*TAGW-1:0]   tag_q  [DEPTH];
  logic [NSRC*TAGW-1:0]   tag_d  [DEPTH];
  logic [NSRC-1:0]        rdy_q  [DEPTH];
  logic [NSRC-1:0]        rdy_d  [DEPTH];
  logic [NSRC*DATAW-1:0]  data_q [DEPTH];
  logic [NSRC*DATAW-1:0]  data_d [DEPTH];

  // Issue stage
  logic                   iss_valid_q, iss_valid_d;
  logic [PAYW-1:0]        iss_pay_q, iss_pay_d;
  logic [NSRC*DATAW-1:0]  iss_data_q, iss_data_d;
  logic [AGEW-1:0]        iss_age_q, iss_age_d;

  logic [CNTW-1:0]        count_q, count_d;

  // Selection / allocation
  logic                   sel_found;
  logic [IDXW-1:0]        sel_idx;
  logic [AGEW-1:0]        sel_age;
  logic                   free_found;
  logic [IDXW-1:0]        free_idx;
  logic                   enq_fire;
  logic                   iss_load;

  // Returns {hit, data} for the lowest-index valid broadcast port matching tag.
  // Tag 0 denotes a hardwired-ready register and never matches.
  function automatic logic [DATAW:0] bc_lookup(input logic [TAGW-1:0] tag,
                                               input logic [NBC-1:0] v,
                                               input logic [NBC*TAGW-1:0] t,
                                               input logic [NBC*DATAW-1:0] d);
    logic [DATAW:0] r;
    r = '0;
    if (tag != '0) begin
      // Descending walk so the lowest matching port is written last.
      for (int b = int'(NBC) - 1; b >= 0; b--) begin
        if (v[b] && (t[b*TAGW +: TAGW] == tag)) begin
          r = {1'b1, d[b*DATAW +: DATAW]};
        end
      end
    end
    return r;
  endfunction

  // Registered-state-only ready: a slot freed this cycle is not visible yet.
  assign enq_ready = !RESET && (count_q < CNTW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign iss_load  = (!iss_valid_q || iss_ready) && !flush;

  // Oldest eligible entry; strict less-than keeps the lowest index on ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (&rdy_q[i]) && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
        sel_age   = age_q[i];
      end
    end
  end

  // Lowest-index free slot from registered valid bits.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  // Next-state for entries and issue stage.
  always_comb begin
    logic [DATAW:0] hit;

    valid_d     = valid_q;
    age_d       = age_q;
    pay_d       = pay_q;
    tag_d       = tag_q;
    rdy_d       = rdy_q;
    data_d      = data_q;
    iss_valid_d = iss_valid_q;
    iss_pay_d   = iss_pay_q;
    iss_data_d  = iss_data_q;
    iss_age_d   = iss_age_q;
    hit         = '0;

    // Wakeup: ready sources are never overwritten.
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int s = 0; s < int'(NSRC); s++) begin
        if (valid_q[i] && !rdy_q[i][s]) begin
          hit = bc_lookup(tag_q[i][s*TAGW +: TAGW], bc_valid, bc_tag, bc_data);
          if (hit[DATAW]) begin
            rdy_d[i][s]                 = 1'b1;
            data_d[i][s*DATAW +: DATAW] = hit[DATAW-1:0];
          end
        end
      end
    end

    // Selective squash of younger entries.
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && (age_q[i] > flush_age)) begin
          valid_d[i] = 1'b0;
        end
      end
      // No load this cycle: a consumed or squashed output simply empties.
      if (iss_ready || (iss_age_q > flush_age)) begin
        iss_valid_d = 1'b0;
      end
    end else if (iss_load) begin
      iss_valid_d = sel_found;
      if (sel_found) begin
        valid_d[sel_idx] = 1'b0;
        iss_pay_d        = pay_q[sel_idx];
        iss_data_d       = data_q[sel_idx];
        iss_age_d        = age_q[sel_idx];
      end
    end

    // Enqueue into a slot that was free in registered state, so it can never
    // collide with the selected or woken entries above.
    if (enq_fire && free_found) begin
      valid_d[free_idx] = 1'b1;
      age_d[free_idx]   = enq_age;
      pay_d[free_idx]   = enq_payload;
      tag_d[free_idx]   = enq_tag;
      for (int s = 0; s < int'(NSRC); s++) begin
        hit = bc_lookup(enq_tag[s*TAGW +: TAGW], bc_valid, bc_tag, bc_data);
        if (enq_busy[s] && hit[DATAW]) begin
          // Result broadcast in the same cycle: the RF value is stale.
          rdy_d[free_idx][s]                 = 1'b1;
          data_d[free_idx][s*DATAW +: DATAW] = hit[DATAW-1:0];
        end else begin
          rdy_d[free_idx][s] = (enq_tag[s*TAGW +: TAGW] == '0) || !enq_busy[s];
          data_d[free_idx][s*DATAW +: DATAW] = enq_data[s*DATAW +: DATAW];
        end
      end
    end
  end

  // Occupancy is the population count of next-state valid bits, which equals
  // +enqueue -issue -flushed and is bounded by DEPTH by construction.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNTW'(valid_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q     <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_pay_q   <= '0;
      iss_data_q  <= '0;
      iss_age_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_q[i]  <= '0;
        pay_q[i]  <= '0;
        tag_q[i]  <= '0;
        rdy_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_pay_q   <= iss_pay_d;
      iss_data_q  <= iss_data_d;
      iss_age_q   <= iss_age_d;
      age_q       <= age_d;
      pay_q       <= pay_d;
      tag_q       <= tag_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_payload = iss_pay_q;
  assign iss_data    = iss_data_q;
  assign iss_age     = iss_age_q;
  assign count       = count_q;

endmodule

// File: tb/tb_issue_queue_param.sv
// Scoreboard bench for issue_queue_param (default parameters).
// Stimulus pushes the expected issue records; a negedge monitor pops and
// compares on every iss_valid & iss_ready handshake and checks stall stability.
module tb_issue_queue_param;

  localparam int DEPTH = 16;

  logic          CLK;
  logic          RESET;
  logic          enq_valid;
  logic          enq_ready;
  logic [31:0]   enq_age;
  logic [137:0]  enq_payload;
  logic [17:0]   enq_tag;
  logic [2:0]    enq_busy;
  logic [95:0]   enq_data;
  logic [1:0]    bc_valid;
  logic [11:0]   bc_tag;
  logic [63:0]   bc_data;
  logic          flush;
  logic [31:0]   flush_age;
  logic          iss_valid;
  logic          iss_ready;
  logic [137:0]  iss_payload;
  logic [95:0]   iss_data;
  logic [31:0]   iss_age;
  logic [4:0]    count;

  issue_queue_param dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_age    (enq_age),
    .enq_payload(enq_payload),
    .enq_tag    (enq_tag),
    .enq_busy   (enq_busy),
    .enq_data   (enq_data),
    .bc_valid   (bc_valid),
    .bc_tag     (bc_tag),
    .bc_data    (bc_data),
    .flush      (flush),
    .flush_age  (flush_age),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_payload(iss_payload),
    .iss_data   (iss_data),
    .iss_age    (iss_age),
    .count      (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]  age;
    logic [95:0]  data;
    logic [137:0] pay;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [137:0] pay_of(input logic [31:0] age);
    return {age, ~age, age, ~age, 10'h2A5};
  endfunction

  function automatic logic [95:0] data_of(input logic [31:0] age);
    return {age ^ 32'h3333_0000, age ^ 32'h2222_0000, age ^ 32'h1111_0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] age, input logic [95:0] data);
    exp_t e;
    e.age  = age;
    e.data = data;
    e.pay  = pay_of(age);
    exp_q.push_back(e);
  endtask

  task automatic enq(input logic [31:0] age, input logic [17:0] tag, input logic [2:0] busy,
                     input logic [95:0] data);
    check("enq_ready_before_enq", 64'(enq_ready), 64'd1);
    enq_valid   = 1'b1;
    enq_age     = age;
    enq_payload = pay_of(age);
    enq_tag     = tag;
    enq_busy    = busy;
    enq_data    = data;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((count != 5'd0 || iss_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 64'(n < max_cyc), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: handshake comparison plus stall stability.
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_age;
  logic [95:0]   prev_data;
  logic [137:0]  prev_pay;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(iss_valid), 64'd1);
        check("stall_age", 64'(iss_age), 64'(prev_age));
        n_vec++;
        if (iss_data !== prev_data || iss_payload !== prev_pay) begin
          n_miss++;
          $display("FAIL stall_data: got %h/%h expected %h/%h", iss_data, iss_payload,
                   prev_data, prev_pay);
        end
      end
      if (iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_issue: got age %0d expected none", iss_age);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("iss_age", 64'(iss_age), 64'(e.age));
          n_vec++;
          if (iss_data !== e.data) begin
            n_miss++;
            $display("FAIL iss_data: got %h expected %h", iss_data, e.data);
          end
          n_vec++;
          if (iss_payload !== e.pay) begin
            n_miss++;
            $display("FAIL iss_payload: got %h expected %h", iss_payload, e.pay);
          end
        end
      end
      prev_stall <= iss_valid && !iss_ready;
      prev_age   <= iss_age;
      prev_data  <= iss_data;
      prev_pay   <= iss_payload;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] d;
    RESET       = 1'b1;
    enq_valid   = 1'b0;
    enq_age     = '0;
    enq_payload = '0;
    enq_tag     = '0;
    enq_busy    = '0;
    enq_data    = '0;
    bc_valid    = '0;
    bc_tag      = '0;
    bc_data     = '0;
    flush       = 1'b0;
    flush_age   = '0;
    iss_ready   = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd0);
    check("rst_iss_age", 64'(iss_age), 64'd0);
    RESET = 1'b0;
    #1;
    check("enq_ready_after_rst", 64'(enq_ready), 64'd1);

    // Minimum latency: ready entry issues two edges after enqueue
    push_exp(32'd5, data_of(32'd5));
    enq(32'd5, 18'd0, 3'b000, data_of(32'd5));
    check("lat_count_1", 64'(count), 64'd1);
    check("lat_valid_0", 64'(iss_valid), 64'd0);
    tick();
    check("lat_valid_1", 64'(iss_valid), 64'd1);
    check("lat_count_0", 64'(count), 64'd0);
    tick();
    check("lat_deassert", 64'(iss_valid), 64'd0);

    // Wakeup by broadcast port 1 (port 0 carries a non-matching tag)
    d = data_of(32'd9);
    push_exp(32'd9, {d[95:64], 32'hDEAD, d[31:0]});
    enq(32'd9, {6'd0, 6'd12, 6'd0}, 3'b010, d);
    tick();
    check("wk_not_ready", 64'(iss_valid), 64'd0);
    bc_valid = 2'b11;
    bc_tag   = {6'd12, 6'd13};
    bc_data  = {32'hDEAD, 32'hBEEF};
    tick();
    bc_valid = 2'b00;
    check("wk_not_yet", 64'(iss_valid), 64'd0);
    tick();
    check("wk_issued", 64'(iss_valid), 64'd1);
    check("wk_age", 64'(iss_age), 64'd9);
    tick();

    // Age ordering behind a stalled output
    iss_ready = 1'b0;
    push_exp(32'd1, data_of(32'd1));
    push_exp(32'd3, data_of(32'd3));
    push_exp(32'd5, data_of(32'd5));
    push_exp(32'd7, data_of(32'd7));
    enq(32'd1, 18'd0, 3'b000, data_of(32'd1));
    enq(32'd7, 18'd0, 3'b000, data_of(32'd7));
    enq(32'd3, 18'd0, 3'b000, data_of(32'd3));
    enq(32'd5, 18'd0, 3'b000, data_of(32'd5));
    tick();
    tick();
    tick();
    check("ord_count", 64'(count), 64'd3);
    check("ord_head_age", 64'(iss_age), 64'd1);
    iss_ready = 1'b1;
    wait_drain("ord_drain", 20);

    // Fill to DEPTH with busy sources; extra enqueues ignored
    for (int i = 0; i < DEPTH; i++) begin
      enq(32'(100 + i), {6'd0, 6'd20, 6'd0}, 3'b010, data_of(32'(100 + i)));
    end
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    enq_valid   = 1'b1;
    enq_age     = 32'd200;
    enq_payload = pay_of(32'd200);
    enq_tag     = '0;
    enq_busy    = '0;
    enq_data    = data_of(32'd200);
    tick();
    tick();
    tick();
    enq_valid = 1'b0;
    check("full_count_hold", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      d = data_of(32'(100 + i));
      push_exp(32'(100 + i), {d[95:64], 32'h2020_2020, d[31:0]});
    end
    bc_valid = 2'b01;
    bc_tag   = {6'd0, 6'd20};
    bc_data  = {32'h0, 32'h2020_2020};
    tick();
    bc_valid = 2'b00;
    wait_drain("full_drain", 60);

    // Selective flush
    for (int i = 1; i <= 4; i++) begin
      enq(32'(2 * i), {12'd0, 6'd30}, 3'b001, data_of(32'(2 * i)));
    end
    check("fl_pre_count", 64'(count), 64'd4);
    flush     = 1'b1;
    flush_age = 32'd4;
    tick();
    flush = 1'b0;
    check("fl_count", 64'(count), 64'd2);
    d = data_of(32'd2);
    push_exp(32'd2, {d[95:32], 32'h3030_3030});
    d = data_of(32'd4);
    push_exp(32'd4, {d[95:32], 32'h3030_3030});
    bc_valid = 2'b10;
    bc_tag   = {6'd30, 6'd0};
    bc_data  = {32'h3030_3030, 32'h0};
    tick();
    bc_valid = 2'b00;
    wait_drain("fl_drain", 20);

    // Reset mid-stream
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq(32'(40 + i), 18'd0, 3'b000, data_of(32'(40 + i)));
    end
    check("mr_count", 64'(count), 64'd3);
    check("mr_valid", 64'(iss_valid), 64'd1);
    check("mr_age", 64'(iss_age), 64'd40);
    RESET = 1'b1;
    #1;
    check("mr_enq_ready_in_rst", 64'(enq_ready), 64'd0);
    tick();
    check("mr_rst_valid", 64'(iss_valid), 64'd0);
    check("mr_rst_count", 64'(count), 64'd0);
    check("mr_rst_age", 64'(iss_age), 64'd0);
    RESET = 1'b0;
    #1;
    check("mr_enq_ready", 64'(enq_ready), 64'd1);
    tick();
    check("final_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/issue_queue_param.md
ISSUE_QUEUE_PARAM -- requirements
Module: issue_queue_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of queue entries (power of 2, >=2).
REQ-002 SHALL have parameter NSRC, default 3: source operands per entry.
REQ-003 SHALL have parameter NBC, default 2: number of result broadcast ports.
REQ-004 SHALL have parameters TAGW=6 (physical reg tag width), DATAW=32 (operand width), PAYW=138 (opaque payload width), AGEW=32 (instruction age width).
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports enq_valid input 1, enq_ready output 1: enqueue handshake.
REQ-008 SHALL have ports enq_age input AGEW, enq_payload input PAYW: instruction number and decoded fields.
REQ-009 SHALL have ports enq_tag input NSRC*TAGW, enq_busy input NSRC, enq_data input NSRC*DATAW: per-source tag, pending flag, register-file value.
REQ-010 SHALL have ports bc_valid input NBC, bc_tag input NBC*TAGW, bc_data input NBC*DATAW: result broadcasts.
REQ-011 SHALL have ports flush input 1, flush_age input AGEW: selective squash.
REQ-012 SHALL have ports iss_valid output 1, iss_ready input 1, iss_payload output PAYW, iss_data output NSRC*DATAW, iss_age output AGEW: issue handshake.
REQ-013 SHALL have port count output clog2(DEPTH+1): occupied entries.

Function
REQ-014 SHALL drive enq_ready = !RESET and count < DEPTH, from registered state only; a slot freed this cycle is not reusable until the next cycle.
REQ-015 SHALL write an accepted enqueue (enq_valid & enq_ready) into the lowest-index free entry.
REQ-016 SHALL mark source s ready at enqueue if tag==0, or enq_busy[s]==0, or any bc_valid port matches the tag that cycle; a same-cycle match captures bc_data instead of enq_data.
REQ-017 SHALL, each cycle, for every valid entry and not-ready source with nonzero tag, set ready and capture bc_data of the lowest-index matching valid broadcast port.
REQ-018 SHALL never overwrite data of an already-ready source; tag 0 never matches a broadcast.
REQ-019 SHALL consider an entry eligible when valid and all NSRC registered ready bits are 1; wakeup in cycle N makes it eligible in cycle N+1.
REQ-020 SHALL select the eligible entry with the smallest enq_age (unsigned); equal ages: lowest index.
REQ-021 SHALL hold issue outputs in a register stage; the stage loads when !iss_valid or iss_ready, and the selected entry is freed on that edge.
REQ-022 SHALL hold iss_payload/iss_data/iss_age stable while iss_valid & !iss_ready.
REQ-023 SHALL give minimum latency 2 edges: enqueue with all sources ready at edge N -> iss_valid=1 after edge N+1.
REQ-024 SHALL deassert iss_valid after an edge where iss_ready=1 and no entry was eligible.
REQ-025 SHALL, on flush, invalidate every entry and the output register whose age > flush_age; flush suppresses the same-cycle enqueue and issue load; wakeups still apply to surviving entries.
REQ-026 SHALL update count each cycle by +1 enqueue, -1 issue load, -N flushed, never exceeding DEPTH.

Reset
REQ-027 SHALL, when RESET=1 at a rising edge, clear all entry valid and ready bits, set iss_valid=0, count=0, and zero iss_payload, iss_data, iss_age.
REQ-028 SHALL give RESET priority over flush, enqueue, wakeup and issue; enq_ready=0 while RESET=1.

Verification
REQ-029 SHALL pass: enqueue age 5, all tags 0, iss_ready=1 -> iss_valid=1 two edges later, iss_age=5, count returns 0.
REQ-030 SHALL pass: enqueue age 9 with src1 tag 12 busy; broadcast tag 12 data 0xDEAD on port 1 -> issues next cycle with src1 data 0xDEAD.
REQ-031 SHALL pass: enqueue ages 7, 3, 5 all ready, iss_ready held 0 then 1 -> issue order 3, 5, 7, output stable while stalled.
REQ-032 SHALL pass: fill DEPTH entries with busy sources -> enq_ready=0, count=DEPTH; further enq_valid ignored.
REQ-033 SHALL pass: entries ages 2, 4, 6, 8, flush with flush_age=4 -> count=2, only ages 2 and 4 ever issue.
REQ-034 SHALL pass: RESET asserted mid-stream with 3 entries and iss_valid=1 -> next cycle iss_valid=0, count=0, enq_ready=1 after RESET drops.
